// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle core sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } seq_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;
    localparam logic [1:0] WB_SEL_IMM   = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I_ALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_LUI, OP_JAL: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Bus wait-cycle counter; flags when a pending request has waited WAIT_MAX cycles.
module seq_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic limit_hit
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count_r;

    // Limit comparison; WAIT_MAX of zero disables the timeout entirely.
    always_comb begin
        limit_hit = 1'b0;
        if (WAIT_MAX != 0) begin
            limit_hit = (count_r == CW'(WAIT_MAX));
        end else begin
            limit_hit = 1'b0;
        end
    end

    // Wait counter: cleared on any non-waiting cycle, counts unready cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && !limit_hit) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and sticky fault.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             fault,
    output logic [2:0]       state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    seq_state_e state_r;
    seq_state_e state_next_s;

    logic       imem_req_s;
    logic       dmem_req_s;
    logic       dmem_we_s;
    logic       ir_we_s;
    logic       pc_we_s;
    logic [1:0] pc_sel_s;
    logic       rf_we_s;
    logic [1:0] wb_sel_s;
    logic       fault_s;
    logic       wait_inc_s;
    logic       wait_clear_s;
    logic       wait_hit_s;

    // Only unready request cycles count; every other cycle clears, which also
    // gives a fresh count on each entry to FETCH or MEM.
    always_comb begin
        wait_inc_s   = ((state_r == ST_FETCH) && !imem_ready) ||
                       ((state_r == ST_MEM)   && !dmem_ready);
        wait_clear_s = !wait_inc_s;
    end

    seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (wait_clear_s),
        .inc       (wait_inc_s),
        .limit_hit (wait_hit_s)
    );

    // Next-state and Moore/handshake decode.
    always_comb begin
        state_next_s = state_r;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        ir_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_sel_s     = PC_SEL_PLUS4;
        rf_we_s      = 1'b0;
        wb_sel_s     = WB_SEL_ALU;
        fault_s      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_we_s      = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (wait_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE:               state_next_s = ST_MEM;
                    OP_R, OP_I_ALU, OP_LUI, OP_JAL:  state_next_s = ST_WB;
                    OP_BRANCH: begin
                        pc_we_s      = 1'b1;
                        pc_sel_s     = branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                        state_next_s = ST_FETCH;
                    end
                    default:                         state_next_s = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we_s      = 1'b1;
                        state_next_s = ST_FETCH;
                    end else if (opcode == OP_LOAD) begin
                        state_next_s = ST_WB;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end else if (wait_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s      = 1'b1;
                pc_we_s      = 1'b1;
                pc_sel_s     = (opcode == OP_JAL) ? PC_SEL_JUMP : PC_SEL_PLUS4;
                case (opcode)
                    OP_JAL:  wb_sel_s = WB_SEL_PC4;
                    OP_LOAD: wb_sel_s = WB_SEL_LOAD;
                    OP_LUI:  wb_sel_s = WB_SEL_IMM;
                    default: wb_sel_s = WB_SEL_ALU;
                endcase
                state_next_s = ST_FETCH;
            end
            ST_FAULT: begin
                fault_s      = 1'b1;
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_FAULT;
            end
        endcase
    end

    // Reset forces every strobe and request low even before the state register clears.
    always_comb begin
        imem_req = imem_req_s & ~reset;
        dmem_req = dmem_req_s & ~reset;
        dmem_we  = dmem_we_s  & ~reset;
        ir_we    = ir_we_s    & ~reset;
        pc_we    = pc_we_s    & ~reset;
        pc_sel   = reset ? PC_SEL_PLUS4 : pc_sel_s;
        rf_we    = rf_we_s    & ~reset;
        wb_sel   = reset ? WB_SEL_ALU : wb_sel_s;
        fault    = fault_s    & ~reset;
        state    = state_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_r;

    // Retire coincides with the PC update; no pc_we ever occurs in FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_r <= '0;
        end else if (pc_we_s) begin
            retired_cnt_r <= retired_cnt_r + CNT_W'(1);
        end else begin
            retired_cnt_r <= retired_cnt_r;
        end
    end

    assign retired_cnt = retired_cnt_r;
`else
    logic unused_cnt_w_s;
    assign unused_cnt_w_s = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (WAIT_MAX=4); retired_cnt checked when SEQ_PERF_CNT_EN is defined.
module tb_multicycle_sequencer;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, fault;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int pcwe_seen = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.WAIT_MAX(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .fault        (fault),
        .state        (state)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    always @(negedge clk) begin
        if (pc_we) pcwe_seen = pcwe_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH with zero-wait buses and checks its latency.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic bt, input int lat);
        int cycles = 0;
        opcode = op; branch_taken = bt; imem_ready = 1'b1; dmem_ready = 1'b1;
        do begin
            tick();
            cycles++;
        end while (state != 3'd0 && cycles < 20);
        chk(tag, cycles, lat);
    endtask

    initial begin
        int base;
        reset = 1'b1; opcode = R; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b0;
        #1;
        chk("rst_state", state, 0);

        // R-type walk
        opcode = R; imem_ready = 1'b1;
        #1; chk("r_fetch_req", imem_req, 1); chk("r_ir_we", ir_we, 1);
        tick(); #1; chk("r_decode", state, 1);
        tick(); #1; chk("r_exec", state, 2); chk("r_exec_rf_we", rf_we, 0);
        tick(); #1; chk("r_wb", state, 4); chk("r_rf_we", rf_we, 1);
        chk("r_wb_sel", wb_sel, 0); chk("r_pc_we", pc_we, 1); chk("r_pc_sel", pc_sel, 0);
        tick(); #1; chk("r_back_fetch", state, 0);

        // LOAD with 3 wait cycles
        opcode = LD; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            #1; chk("ld_wait_state", state, 3); chk("ld_dmem_req", dmem_req, 1); chk("ld_dmem_we", dmem_we, 0);
            tick();
        end
        dmem_ready = 1'b1;
        #1; chk("ld_req_4th", dmem_req, 1); chk("ld_mem_pc_we", pc_we, 0);
        tick(); #1; chk("ld_wb", state, 4); chk("ld_wb_sel", wb_sel, 1); chk("ld_rf_we", rf_we, 1);
        tick(); #1; chk("ld_back_fetch", state, 0);

        // BRANCH taken / not taken
        for (int t = 1; t >= 0; t--) begin
            opcode = BR; branch_taken = 1'(t); imem_ready = 1'b1;
            #1; chk("br_f_rf_we", rf_we, 0);
            tick(); #1; chk("br_d_rf_we", rf_we, 0);
            tick(); #1; chk("br_exec", state, 2); chk("br_pc_we", pc_we, 1);
            chk("br_pc_sel", pc_sel, t ? 32'd1 : 32'd0); chk("br_rf_we", rf_we, 0);
            tick(); #1; chk("br_back_fetch", state, 0);
        end

        // STORE, JAL, LUI outputs
        opcode = ST; imem_ready = 1'b1; dmem_ready = 1'b1;
        tick(); tick(); tick();
        #1; chk("st_mem", state, 3); chk("st_we", dmem_we, 1); chk("st_pc_we", pc_we, 1);
        chk("st_pc_sel", pc_sel, 0); chk("st_rf_we", rf_we, 0);
        tick(); #1; chk("st_back_fetch", state, 0);
        opcode = JAL;
        tick(); tick(); tick();
        #1; chk("jal_pc_sel", pc_sel, 2); chk("jal_wb_sel", wb_sel, 2);
        tick();
        opcode = LUI;
        tick(); tick(); tick();
        #1; chk("lui_wb_sel", wb_sel, 3); chk("lui_pc_sel", pc_sel, 0);
        tick();

        // Illegal opcode -> sticky fault
        opcode = BAD; imem_ready = 1'b1;
        tick(); tick();
        #1; chk("ill_state", state, 5);
        for (int i = 0; i < 20; i++) begin
            #1; chk("ill_fault", fault, 1); chk("ill_no_req", imem_req, 0);
            tick();
        end
        reset = 1'b1;
        #1; chk("ill_rst_fault", fault, 0);
        tick(); reset = 1'b0;
        #1; chk("ill_rst_state", state, 0); chk("ill_rst_fault2", fault, 0);

        // Fetch timeout at WAIT_MAX=4
        opcode = R; imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; chk("to_fetch_state", state, 0); chk("to_imem_req", imem_req, 1);
            tick();
        end
        #1; chk("to_state", state, 5); chk("to_fault", fault, 1);
        do_reset();
        // ready in the limit cycle wins
        for (int i = 0; i < 4; i++) tick();
        imem_ready = 1'b1;
        #1; chk("lim_ir_we", ir_we, 1);
        tick(); #1; chk("lim_decode", state, 1); chk("lim_no_fault", fault, 0);
        tick(); tick(); tick();
        #1; chk("lim_back_fetch", state, 0);

        // Data bus timeout
        opcode = LD; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) tick();
        #1; chk("dto_fault", fault, 1);
        do_reset();

        // Mixed instruction stream: latency and retire count
        base = pcwe_seen;
        run_instr("lat_r", R, 1'b0, 4);
        run_instr("lat_i", IA, 1'b0, 4);
        run_instr("lat_ld", LD, 1'b0, 5);
        run_instr("lat_st", ST, 1'b0, 4);
        run_instr("lat_bt", BR, 1'b1, 3);
        run_instr("lat_bn", BR, 1'b0, 3);
        run_instr("lat_lui", LUI, 1'b0, 4);
        run_instr("lat_jal", JAL, 1'b0, 4);
        run_instr("lat_r2", R, 1'b0, 4);
        run_instr("lat_ld2", LD, 1'b0, 5);
        #1; chk("pc_we_pulses", pcwe_seen - base, 10);
`ifdef SEQ_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 10);
`endif

        // Reset in the middle of MEM
        opcode = ST; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        #1; chk("mid_mem_req", dmem_req, 1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        #1; chk("mid_rst_req", dmem_req, 0); chk("mid_rst_state", state, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("mid_rst_cnt", retired_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
